// File: rtl/ahb_lite_master.sv
// Command-to-AHB-Lite bridge: SINGLE transfers, plus INCR4 bursts when
// AHB_MASTER_INCR4_BURST_EN is defined. Pipelined address/data phases with ERROR abort.
module ahb_lite_master (
   input  logic         HCLK,
   input  logic         HRESET,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_write,
   input  logic         cmd_burst,
   input  logic [2:0]   cmd_size,
   input  logic [31:0]  cmd_addr,
   input  logic [127:0] cmd_wdata,
   output logic         rsp_valid,
   output logic [31:0]  rsp_rdata,
   output logic         rsp_err,
   output logic         rsp_last,
   output logic [31:0]  HADDR,
   output logic [1:0]   HTRANS,
   output logic         HWRITE,
   output logic [2:0]   HSIZE,
   output logic [2:0]   HBURST,
   output logic [3:0]   HPROT,
   output logic [31:0]  HWDATA,
   input  logic [31:0]  HRDATA,
   input  logic         HREADY,
   input  logic         HRESP
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StNseq  = 3'd1;
   localparam logic [2:0] StSeq   = 3'd2;
   localparam logic [2:0] StDrain = 3'd3;
   localparam logic [2:0] StErr   = 3'd4;

   localparam logic [1:0] TransIdle = 2'b00;
   localparam logic [1:0] TransNseq = 2'b10;
   localparam logic [1:0] TransSeq  = 2'b11;

   logic [2:0]   state_q, state_d;
   logic [31:0]  haddr_q, haddr_d;
   logic [1:0]   htrans_q, htrans_d;
   logic         hwrite_q, hwrite_d;
   logic [2:0]   hsize_q, hsize_d;
   logic [2:0]   hburst_q, hburst_d;
   logic [31:0]  hwdata_q, hwdata_d;
   logic [127:0] wdata_q, wdata_d;
   logic         burst_q, burst_d;
   logic [1:0]   abeat_q, abeat_d;
   logic [1:0]   dbeat_q, dbeat_d;
   logic         dph_q, dph_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic [31:0]  rsp_rdata_q, rsp_rdata_d;
   logic         rsp_err_q, rsp_err_d;
   logic         rsp_last_q, rsp_last_d;

   logic         cmd_is_burst;
   logic         burst_bad;
   logic         cmd_bad;
   logic         ready_w;
   logic [1:0]   last_beat;

`ifdef AHB_MASTER_INCR4_BURST_EN
   assign cmd_is_burst = cmd_burst;
   // Misaligned start or a burst that would cross a 1KB boundary.
   assign burst_bad    = (cmd_addr[1:0] != 2'b00) || (cmd_addr[9:0] > 10'h3F0);
`else
   logic unused_burst;
   assign unused_burst = cmd_burst;
   assign cmd_is_burst = 1'b0;
   assign burst_bad    = 1'b0;
`endif

   assign cmd_bad   = cmd_is_burst ? burst_bad : (cmd_size > 3'd2);
   assign ready_w   = (state_q == StIdle) && !dph_q && !HRESET;
   assign last_beat = burst_q ? 2'd3 : 2'd0;

   always_comb begin
      state_d     = state_q;
      haddr_d     = haddr_q;
      htrans_d    = htrans_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hburst_d    = hburst_q;
      hwdata_d    = hwdata_q;
      wdata_d     = wdata_q;
      burst_d     = burst_q;
      abeat_d     = abeat_q;
      dbeat_d     = dbeat_q;
      dph_d       = dph_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'h0;
      rsp_err_d   = 1'b0;
      rsp_last_d  = 1'b0;

      case (state_q)
         StIdle: begin
            if (cmd_valid && ready_w) begin
               if (cmd_bad) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_last_d  = 1'b1;
               end else begin
                  state_d  = StNseq;
                  htrans_d = TransNseq;
                  haddr_d  = cmd_addr;
                  hwrite_d = cmd_write;
                  hsize_d  = cmd_is_burst ? 3'b010 : cmd_size;
                  hburst_d = cmd_is_burst ? 3'b011 : 3'b000;
                  burst_d  = cmd_is_burst;
                  wdata_d  = cmd_wdata;
                  abeat_d  = 2'd0;
               end
            end
         end

         StNseq, StSeq, StDrain: begin
            if (dph_q && HRESP && !HREADY) begin
               // First ERROR cycle: cancel everything still queued.
               state_d  = StErr;
               htrans_d = TransIdle;
            end else if (HREADY) begin
               if (dph_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = HRESP;
                  rsp_last_d  = HRESP || (dbeat_q == last_beat);
                  rsp_rdata_d = hwrite_q ? 32'h0 : HRDATA;
               end
               if (dph_q && HRESP) begin
                  state_d  = StIdle;
                  htrans_d = TransIdle;
                  dph_d    = 1'b0;
               end else if (state_q == StDrain) begin
                  state_d = StIdle;
                  dph_d   = 1'b0;
               end else begin
                  dph_d    = 1'b1;
                  dbeat_d  = abeat_q;
                  hwdata_d = wdata_q[{abeat_q, 5'd0} +: 32];
                  if (abeat_q == last_beat) begin
                     state_d  = StDrain;
                     htrans_d = TransIdle;
                  end else begin
                     state_d  = StSeq;
                     htrans_d = TransSeq;
                     haddr_d  = haddr_q + 32'd4;
                     abeat_d  = abeat_q + 2'd1;
                  end
               end
            end
         end

         StErr: begin
            if (HREADY) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_last_d  = 1'b1;
               rsp_rdata_d = hwrite_q ? 32'h0 : HRDATA;
               state_d     = StIdle;
               dph_d       = 1'b0;
            end
         end

         default: begin
            state_d  = StIdle;
            htrans_d = TransIdle;
            dph_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= StIdle;
         haddr_q     <= 32'h0;
         htrans_q    <= TransIdle;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'b000;
         hburst_q    <= 3'b000;
         hwdata_q    <= 32'h0;
         wdata_q     <= 128'h0;
         burst_q     <= 1'b0;
         abeat_q     <= 2'd0;
         dbeat_q     <= 2'd0;
         dph_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         rsp_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         haddr_q     <= haddr_d;
         htrans_q    <= htrans_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hburst_q    <= hburst_d;
         hwdata_q    <= hwdata_d;
         wdata_q     <= wdata_d;
         burst_q     <= burst_d;
         abeat_q     <= abeat_d;
         dbeat_q     <= dbeat_d;
         dph_q       <= dph_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_last_q  <= rsp_last_d;
      end
   end

   assign cmd_ready = ready_w;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_last  = rsp_last_q;
   assign HADDR     = haddr_q;
   assign HTRANS    = htrans_q;
   assign HWRITE    = hwrite_q;
   assign HSIZE     = hsize_q;
   assign HBURST    = hburst_q;
   assign HPROT     = 4'b0011;
   assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master: a transaction-level model predicts every bus
// cycle and response while the bench plays the AHB slave.
module tb_ahb_lite_master;

`ifdef AHB_MASTER_INCR4_BURST_EN
   localparam bit BurstEn = 1'b1;
`else
   localparam bit BurstEn = 1'b0;
`endif

   logic         HCLK = 1'b0;
   logic         HRESET;
   logic         cmd_valid, cmd_ready, cmd_write, cmd_burst;
   logic [2:0]   cmd_size;
   logic [31:0]  cmd_addr;
   logic [127:0] cmd_wdata;
   logic         rsp_valid, rsp_err, rsp_last;
   logic [31:0]  rsp_rdata;
   logic [31:0]  HADDR, HWDATA, HRDATA;
   logic [1:0]   HTRANS;
   logic         HWRITE, HREADY, HRESP;
   logic [2:0]   HSIZE, HBURST;
   logic [3:0]   HPROT;

   int n_vec = 0;
   int n_err = 0;

   ahb_lite_master dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_burst (cmd_burst),
      .cmd_size  (cmd_size),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .rsp_last  (rsp_last),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HPROT     (HPROT),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADY    (HREADY),
      .HRESP     (HRESP)
   );

   always #5 HCLK = ~HCLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_haddr"}, HADDR, 32'h0);
      check_eq({tag, "_htrans"}, {30'h0, HTRANS}, 32'h0);
      check_eq({tag, "_hwrite"}, {31'h0, HWRITE}, 32'h0);
      check_eq({tag, "_hsize"}, {29'h0, HSIZE}, 32'h0);
      check_eq({tag, "_hburst"}, {29'h0, HBURST}, 32'h0);
      check_eq({tag, "_hwdata"}, HWDATA, 32'h0);
      check_eq({tag, "_rsp"}, {29'h0, rsp_valid, rsp_err, rsp_last}, 32'h0);
      check_eq({tag, "_rdata"}, rsp_rdata, 32'h0);
      check_eq({tag, "_ready"}, {31'h0, cmd_ready}, 32'h0);
   endtask

   // mode: 0 always ready, 1 random waits, 2 three wait states on the data phase.
   // err_beat: data beat that gets a two-cycle ERROR (-1 none). rst_cyc: bus cycle to reset in.
   task automatic run_cmd(input bit wr, input bit bu, input logic [2:0] sz,
                          input logic [31:0] ad, input logic [127:0] wd,
                          input int mode, input int err_beat, input int rst_cyc);
      bit be, bad, errd, done, exp_rsp, exp_err, exp_last, hr, hp;
      int n, a, d, stall;
      logic [31:0] exp_rd, rd;
      logic [2:0] exp_size, exp_burst;
      logic [1:0] exp_trans;
      be        = BurstEn && bu;
      n         = be ? 4 : 1;
      bad       = be ? ((ad[1:0] != 2'b00) || (ad[9:0] > 10'h3F0)) : (sz > 3'd2);
      exp_size  = be ? 3'b010 : sz;
      exp_burst = be ? 3'b011 : 3'b000;

      cmd_valid = 1'b1; cmd_write = wr; cmd_burst = bu; cmd_size = sz;
      cmd_addr = ad; cmd_wdata = wd; HREADY = 1'b1; HRESP = 1'b0;
      #1;
      check_eq("cmd_ready", {31'h0, cmd_ready}, 32'h1);
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      if (bad) begin
         check_eq("reject_rsp", {29'h0, rsp_valid, rsp_err, rsp_last}, 32'h7);
         check_eq("reject_htrans", {30'h0, HTRANS}, 32'h0);
         return;
      end

      a = 0; d = -1; errd = 0; done = 0; exp_rsp = 0; stall = 0;
      exp_err = 0; exp_last = 0; exp_rd = 0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (cyc == rst_cyc) begin
            HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
            @(posedge HCLK); #1;
            check_all_zero("midrst");
            HRESET = 1'b0;
            @(posedge HCLK); #1;
            check_eq("rst_release_ready", {31'h0, cmd_ready}, 32'h1);
            check_eq("rst_release_rsp", {31'h0, rsp_valid}, 32'h0);
            @(posedge HCLK); #1;
            check_eq("rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
            check_eq("rst_htrans", {30'h0, HTRANS}, 32'h0);
            return;
         end
         check_eq("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rsp});
         if (exp_rsp) begin
            check_eq("rsp_rdata", rsp_rdata, exp_rd);
            check_eq("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
            check_eq("rsp_last", {31'h0, rsp_last}, {31'h0, exp_last});
            if (exp_last) begin
               done = 1;
               break;
            end
         end
         exp_trans = (!errd && a < n) ? ((a == 0) ? 2'b10 : 2'b11) : 2'b00;
         check_eq("htrans", {30'h0, HTRANS}, {30'h0, exp_trans});
         check_eq("hprot", {28'h0, HPROT}, 32'h3);
         if (exp_trans != 2'b00) begin
            check_eq("haddr", HADDR, ad + 32'(4 * a));
            check_eq("hwrite", {31'h0, HWRITE}, {31'h0, wr});
            check_eq("hsize", {29'h0, HSIZE}, {29'h0, exp_size});
            check_eq("hburst", {29'h0, HBURST}, {29'h0, exp_burst});
         end
         if (d >= 0 && wr && !errd) check_eq("hwdata", HWDATA, wd[d*32 +: 32]);

         hp = 1'b0;
         if (errd) begin
            hr = 1'b1; hp = 1'b1;
         end else if (d >= 0 && d == err_beat) begin
            hr = 1'b0; hp = 1'b1;
         end else if (mode == 1) begin
            hr = ($urandom_range(0, 2) != 0);
         end else if (mode == 2 && d >= 0 && stall < 3) begin
            hr = 1'b0; stall++;
         end else begin
            hr = 1'b1;
         end
         rd = $urandom;
         HREADY = hr; HRESP = hp; HRDATA = rd;
         @(posedge HCLK); #1;

         exp_rsp = 0;
         if (errd) begin
            exp_rsp = 1; exp_err = 1; exp_last = 1; exp_rd = wr ? 32'h0 : rd; d = -1;
         end else if (d >= 0 && hp && !hr) begin
            errd = 1;
         end else if (hr) begin
            if (d >= 0) begin
               exp_rsp = 1; exp_err = 0; exp_last = (d == n - 1); exp_rd = wr ? 32'h0 : rd;
            end
            if (a < n) begin
               d = a; a++;
            end else begin
               d = -1;
            end
         end
      end
      HREADY = 1'b1; HRESP = 1'b0;
      if (!done) check_eq("cmd_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ad;
      logic [127:0] wd;
      HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst = 1'b0;
      cmd_size = 3'd0; cmd_addr = 32'h0; cmd_wdata = 128'h0;
      HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      check_all_zero("reset");
      HRESET = 1'b0;
      @(posedge HCLK); #1;
      check_eq("post_reset_ready", {31'h0, cmd_ready}, 32'h1);

      // Directed scenarios.
      run_cmd(1'b1, 1'b0, 3'd2, 32'h10, {96'h0, 32'hDEADBEEF}, 0, -1, -1);
      run_cmd(1'b0, 1'b1, 3'd2, 32'h100, 128'h0, 0, -1, -1);
      run_cmd(1'b0, 1'b0, 3'd2, 32'h20, 128'h0, 2, -1, -1);
      run_cmd(1'b1, 1'b1, 3'd2, 32'h200,
              128'h44444444_33333333_22222222_11111111, 0, 0, -1);
      run_cmd(1'b0, 1'b1, 3'd2, 32'h3F4, 128'h0, 0, -1, -1);
      run_cmd(1'b0, 1'b0, 3'd5, 32'h40, 128'h0, 0, -1, -1);
      run_cmd(1'b1, 1'b1, 3'd2, 32'h300,
              128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 0, -1, BurstEn ? 2 : 1);

      // Randomized commands, including boundary addresses, bad sizes and ERRORs.
      for (int i = 0; i < 40; i++) begin
         ad = $urandom;
         if ($urandom_range(0, 2) != 0) ad[1:0] = 2'b00;
         if ($urandom_range(0, 3) == 0) ad[9:0] = 10'(10'h3E8 + 4 * $urandom_range(0, 5));
         wd = {$urandom, $urandom, $urandom, $urandom};
         run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 3)), ad, wd, 1,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
